// File: rtl/ping_pong_line_reader.sv
// Read-side sequencer for the ping_pong_ram line buffer: sweeps one line of
// addresses per line_end and streams the returned pixels through a small FIFO.
module ping_pong_line_reader #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 8,
  parameter int LINE_WIDTH = 1280,
  parameter int BASE_ADDR  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_end,
  output logic              re,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = $clog2(LINE_WIDTH + 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + LINE_WIDTH - 1);
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(LINE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_r, state_n_s;
  logic                re_r, re_n_s;
  logic [ADDR_W-1:0]   addr_r, addr_n_s;
  logic                cap_r;
  logic                busy_r, busy_n_s;
  logic                pending_r, pending_n_s;
  logic                overrun_r;
  logic [DATA_W-1:0]   fifo_mem_r [4];
  logic [1:0]          wr_ptr_r, rd_ptr_r;
  logic [2:0]          count_r;
  logic [CNT_W-1:0]    idx_r;

  logic                valid_s, push_s, pop_s, eol_acc_s, late_s, room_s;
  logic [2:0]          count_next_s;

  assign valid_s      = (count_r != 3'd0);
  assign push_s       = cap_r;
  assign pop_s        = valid_s & pix_ready;
  assign eol_acc_s    = pop_s & (idx_r == LAST_IDX);
  assign late_s       = line_end & (busy_r | pending_r);
  assign count_next_s = count_r + {2'b00, push_s} - {2'b00, pop_s};
  // The read issued next is allowed only if everything already owed still fits the FIFO.
  assign room_s       = (({1'b0, count_next_s} + {3'b000, re_r}) <= 4'd3);

  // Next-state, read-issue and start bookkeeping.
  always_comb begin
    state_n_s   = state_r;
    re_n_s      = 1'b0;
    addr_n_s    = addr_r;
    busy_n_s    = busy_r;
    pending_n_s = pending_r | late_s;
    case (state_r)
      IDLE: begin
        if (line_end | pending_r) begin
          state_n_s   = READ;
          re_n_s      = room_s;
          addr_n_s    = FIRST_ADDR;
          busy_n_s    = 1'b1;
          pending_n_s = 1'b0;
        end else begin
          state_n_s   = IDLE;
        end
      end
      READ: begin
        if (re_r && (addr_r == LAST_ADDR)) begin
          state_n_s = DRAIN;
          re_n_s    = 1'b0;
        end else begin
          re_n_s    = room_s;
          addr_n_s  = re_r ? (addr_r + ADDR_W'(1)) : addr_r;
        end
      end
      DRAIN: begin
        if (eol_acc_s) begin
          // A pending (or coincident) start is consumed by going straight back to READ.
          if (pending_r | line_end) begin
            state_n_s   = READ;
            re_n_s      = room_s;
            addr_n_s    = FIRST_ADDR;
            busy_n_s    = 1'b1;
            pending_n_s = 1'b0;
          end else begin
            state_n_s   = IDLE;
            addr_n_s    = FIRST_ADDR;
            busy_n_s    = 1'b0;
          end
        end else begin
          state_n_s = DRAIN;
        end
      end
      default: begin
        state_n_s   = IDLE;
        addr_n_s    = FIRST_ADDR;
        busy_n_s    = 1'b0;
        pending_n_s = 1'b0;
      end
    endcase
  end

  // Control, FIFO bookkeeping and output-index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      re_r      <= 1'b0;
      addr_r    <= FIRST_ADDR;
      cap_r     <= 1'b0;
      busy_r    <= 1'b0;
      pending_r <= 1'b0;
      overrun_r <= 1'b0;
      wr_ptr_r  <= 2'd0;
      rd_ptr_r  <= 2'd0;
      count_r   <= 3'd0;
      idx_r     <= CNT_W'(0);
    end else begin
      state_r   <= state_n_s;
      re_r      <= re_n_s;
      addr_r    <= addr_n_s;
      cap_r     <= re_r;
      busy_r    <= busy_n_s;
      pending_r <= pending_n_s;
      overrun_r <= late_s;
      count_r   <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 2'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 2'd1;
        idx_r    <= eol_acc_s ? CNT_W'(0) : (idx_r + CNT_W'(1));
      end
    end
  end

  // FIFO storage; contents are don't-care until count_r covers them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= read_data;
    end
  end

  assign re        = re_r;
  assign read_addr = addr_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;
  assign pix_valid = valid_s;
  assign pix_data  = valid_s ? fifo_mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign pix_sol   = valid_s & (idx_r == CNT_W'(0));
  assign pix_eol   = valid_s & (idx_r == LAST_IDX);

endmodule

// File: tb/tb_ping_pong_line_reader.sv
// Bench for ping_pong_line_reader (LINE_WIDTH=4): directed table, hand sequences
// and random traffic, all checked against a line-level scoreboard model.
module tb_ping_pong_line_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_end = 1'b0;
  logic        re;
  logic [10:0] read_addr;
  logic [7:0]  read_data = 8'h00;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready = 1'b1;
  logic        pix_sol, pix_eol, busy, overrun;

  ping_pong_line_reader #(.ADDR_W(11), .DATA_W(8), .LINE_WIDTH(4), .BASE_ADDR(1)) dut (
    .clk(clk), .reset(reset), .line_end(line_end), .re(re), .read_addr(read_addr),
    .read_data(read_data), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_sol(pix_sol), .pix_eol(pix_eol), .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line contents: each started line consumes the next entry.
  logic [7:0] line_mem [512][4];

  // Reference model state (line-level view of the stream).
  logic [7:0] exp_q [$];
  bit  m_busy = 0, m_pending = 0, exp_ovr = 0, stall_prev = 0, chk_en = 0;
  int  m_idx = 0, m_started = 0, rd_line = 0, rd_pos = 0;
  int  issued = 0, accepted = 0, lines_done = 0, ovr_seen = 0;
  bit  acc, eol_acc, late, start, p;

  // RAM model plus scoreboard update at every active edge.
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_busy = 0; m_pending = 0; m_idx = 0; exp_ovr = 0; stall_prev = 0;
      issued = 0; accepted = 0; rd_pos = 0; rd_line = m_started;
    end else begin
      if (re) begin
        if (read_addr >= 11'd1 && read_addr <= 11'd4)
          read_data <= line_mem[rd_line % 512][int'(read_addr) - 1];
        else
          read_data <= 8'h00;
        issued++;
        if (rd_pos == 3) begin rd_pos = 0; rd_line++; end
        else rd_pos++;
      end
      acc = pix_valid && pix_ready;
      eol_acc = acc && (m_idx == 3);
      stall_prev = pix_valid && !pix_ready;
      if (acc) begin
        accepted++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_idx = eol_acc ? 0 : m_idx + 1;
        if (eol_acc) lines_done++;
      end
      late = line_end && (m_busy || m_pending);
      exp_ovr = late;
      start = line_end && !late;
      p = m_pending || late;
      if (eol_acc) begin
        if (p) begin start = 1; p = 0; end
        else m_busy = 0;
      end
      m_pending = p;
      if (start) begin
        m_busy = 1;
        for (int j = 0; j < 4; j++) exp_q.push_back(line_mem[m_started % 512][j]);
        m_started++;
      end
    end
  end

  // Continuous checks, sampled half a cycle after the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      if (stall_prev) chk("hold_valid", {31'd0, pix_valid}, 32'd1);
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_pix: got data %0h with no pixel owed at %0t", pix_data, $time);
        end else begin
          chk("pix_data", {24'd0, pix_data}, {24'd0, exp_q[0]});
          chk("pix_sol", {31'd0, pix_sol}, {31'd0, (m_idx == 0)});
          chk("pix_eol", {31'd0, pix_eol}, {31'd0, (m_idx == 3)});
        end
      end else begin
        chk("flags_idle", {30'd0, pix_sol, pix_eol}, 32'd0);
      end
      if (re) chk("read_addr", {21'd0, read_addr}, 32'(1 + rd_pos));
      chk("outstanding", {31'd0, ((issued - accepted + int'(re)) <= 4)}, 32'd1);
      if (overrun) ovr_seen++;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    pix_ready = 1'b1;
    line_end  = 1'b0;
    while ((exp_q.size() != 0 || m_busy || m_pending) && n < limit) begin
      step();
      n++;
    end
    chk("drain_timeout", {31'd0, (n < limit)}, 32'd1);
    step();
  endtask

  task automatic pulse_line_end();
    line_end = 1'b1;
    step();
    line_end = 1'b0;
  endtask

  typedef struct {
    logic le; logic rdy; logic re; logic [10:0] addr; logic valid;
    logic [7:0] data; logic sol; logic eol; logic busy; logic ovr;
  } vec_t;
  vec_t tbl [8];

  int l0, o0, a0, n;
  logic [5:0] pat;

  initial begin
    for (int k = 0; k < 512; k++)
      for (int j = 0; j < 4; j++) line_mem[k][j] = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      line_mem[k][0] = 8'hAA; line_mem[k][1] = 8'hBB;
      line_mem[k][2] = 8'hCC; line_mem[k][3] = 8'hDD;
    end
    line_mem[3][0] = 8'h11; line_mem[3][1] = 8'h22;
    line_mem[3][2] = 8'h33; line_mem[3][3] = 8'h44;

    //           le    rdy   re    addr    valid data   sol   eol   busy  ovr
    tbl[0] = '{1'b1, 1'b1, 1'b1, 11'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 11'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 11'd3, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 11'd4, 1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 11'd0, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 11'd0, 1'b1, 8'hDD, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    step(); step();
    reset = 1'b0;
    step();
    chk("rst_re", {31'd0, re}, 32'd0);
    chk("rst_addr", {21'd0, read_addr}, 32'd1);
    chk("rst_out", {20'd0, pix_data, pix_valid, pix_sol, pix_eol, busy}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk_en = 1;

    // Single line, ready held high: exact cycle-by-cycle timing.
    for (int i = 0; i < 8; i++) begin
      line_end = tbl[i].le;
      pix_ready = tbl[i].rdy;
      step();
      chk("t_re", {31'd0, re}, {31'd0, tbl[i].re});
      if (tbl[i].re) chk("t_addr", {21'd0, read_addr}, {21'd0, tbl[i].addr});
      chk("t_valid", {31'd0, pix_valid}, {31'd0, tbl[i].valid});
      if (tbl[i].valid) chk("t_data", {24'd0, pix_data}, {24'd0, tbl[i].data});
      chk("t_sol", {31'd0, pix_sol}, {31'd0, tbl[i].sol});
      chk("t_eol", {31'd0, pix_eol}, {31'd0, tbl[i].eol});
      chk("t_busy", {31'd0, busy}, {31'd0, tbl[i].busy});
      chk("t_ovr", {31'd0, overrun}, {31'd0, tbl[i].ovr});
    end
    line_end = 1'b0;

    // Stalling consumer.
    pat = 6'b101001;
    l0 = lines_done;
    line_end = 1'b1;
    pix_ready = pat[0];
    step();
    line_end = 1'b0;
    for (int k = 1; k < 30; k++) begin
      pix_ready = pat[k % 6];
      step();
    end
    wait_idle(100);
    chk("stall_lines", 32'(lines_done - l0), 32'd1);

    // Back-to-back line_end during a line.
    l0 = lines_done; o0 = ovr_seen;
    pulse_line_end();
    step(); step();
    pulse_line_end();
    wait_idle(100);
    chk("b2b_lines", 32'(lines_done - l0), 32'd2);
    chk("b2b_ovr", 32'(ovr_seen - o0), 32'd1);

    // Three pulses during one line.
    l0 = lines_done; o0 = ovr_seen;
    pulse_line_end();
    step();
    pulse_line_end();
    step();
    pulse_line_end();
    wait_idle(100);
    chk("three_lines", 32'(lines_done - l0), 32'd2);
    chk("three_ovr", 32'(ovr_seen - o0), 32'd2);

    // Reset after two accepted pixels.
    a0 = accepted;
    pulse_line_end();
    n = 0;
    while ((accepted - a0) < 2 && n < 40) begin step(); n++; end
    chk("rst_wait", {31'd0, (n < 40)}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_re", {31'd0, re}, 32'd0);
    chk("mid_rst_addr", {21'd0, read_addr}, 32'd1);
    chk("mid_rst_out", {20'd0, pix_data, pix_valid, pix_sol, pix_eol, busy}, 32'd0);
    chk("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    for (int k = 0; k < 10; k++) step();
    l0 = lines_done;
    pulse_line_end();
    chk("post_rst_addr", {21'd0, read_addr}, 32'd1);
    wait_idle(100);
    chk("post_rst_lines", 32'(lines_done - l0), 32'd1);

    // line_end coincident with eol acceptance.
    l0 = lines_done; o0 = ovr_seen;
    pulse_line_end();
    n = 0;
    while (!(pix_valid && pix_eol) && n < 40) begin step(); n++; end
    chk("eol_wait", {31'd0, (n < 40)}, 32'd1);
    pulse_line_end();
    chk("coin_ovr", {31'd0, overrun}, 32'd1);
    chk("coin_re", {31'd0, re}, 32'd1);
    chk("coin_addr", {21'd0, read_addr}, 32'd1);
    chk("coin_busy", {31'd0, busy}, 32'd1);
    wait_idle(100);
    chk("coin_lines", 32'(lines_done - l0), 32'd2);
    chk("coin_ovr_cnt", 32'(ovr_seen - o0), 32'd1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      line_end  = ($urandom_range(0, 11) == 0);
      pix_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0;
    wait_idle(300);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
